// File: rtl/led_catcher_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_catcher_ctrl
// Purpose  : LED catcher game controller. Scrolls a one-hot LED across the
//            board, judges each button press as a hit (lit LED on the target
//            index) or a miss, keeps a saturating score, and freezes the
//            display for a fixed interval after every press.
// Ports    : clk     - system clock
//            rst_n   - asynchronous active-low reset
//            btn     - debounced button level, synchronous to clk
//            led     - LED drive, one-hot while running or frozen
//            score   - hit count, saturates at 255
//            hit     - one-cycle pulse on a hit
//            miss    - one-cycle pulse on a miss
//            frozen  - high while the display is frozen after a press
// Options  : LED_CATCHER_SPEEDUP_EN - when defined, every hit shortens the
//            step period by STEP_DEC, floored at STEP_MIN.
// Revision : 1.0 - initial release
// ============================================================================
module led_catcher_ctrl #(
  parameter int NUM_LEDS      = 16,
  parameter int TARGET_IDX    = 7,
  parameter int STEP_CYCLES   = 10_000_000,
  parameter int FREEZE_CYCLES = 300_000_000,
  parameter int STEP_DEC      = 500_000,
  parameter int STEP_MIN      = 2_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn,
  output logic [NUM_LEDS-1:0] led,
  output logic [7:0]          score,
  output logic                hit,
  output logic                miss,
  output logic                frozen
);

  localparam int POS_W  = $clog2(NUM_LEDS);
  localparam int STEP_W = $clog2(STEP_CYCLES + 1);
  localparam int FRZ_W  = $clog2(FREEZE_CYCLES + 1);

  localparam logic [POS_W-1:0]    LAST_POS = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0]    TGT_POS  = POS_W'(TARGET_IDX);
  localparam logic [FRZ_W-1:0]    FRZ_LAST = FRZ_W'(FREEZE_CYCLES - 1);
  localparam logic [NUM_LEDS-1:0] LED_POS0 = NUM_LEDS'(1);

  // Elaboration-time sanity check on the parameter set.
  generate
    if (NUM_LEDS < 2 || TARGET_IDX < 0 || TARGET_IDX >= NUM_LEDS ||
        STEP_CYCLES < 2 || FREEZE_CYCLES < 1 ||
        STEP_DEC < 0 || STEP_MIN < 1 || STEP_MIN > STEP_CYCLES) begin : g_param_check
      $error("led_catcher_ctrl: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FREEZE = 2'd2
  } state_t;

  state_t              state;
  logic                btn_q;
  logic [POS_W-1:0]    pos;
  logic [STEP_W-1:0]   step_cnt;
  logic [FRZ_W-1:0]    frz_cnt;
  logic [STEP_W-1:0]   period;

  logic                press;
  logic                step_tc;
  logic [POS_W-1:0]    pos_next;

  assign press    = btn & ~btn_q;
  assign step_tc  = (step_cnt == period - 1'b1);
  assign pos_next = (pos == LAST_POS) ? '0 : pos + 1'b1;

`ifdef LED_CATCHER_SPEEDUP_EN
  localparam logic [STEP_W-1:0] PERIOD_INIT = STEP_W'(STEP_CYCLES);
  localparam logic [STEP_W-1:0] PERIOD_DEC  = STEP_W'(STEP_DEC);
  localparam logic [STEP_W-1:0] PERIOD_MIN  = STEP_W'(STEP_MIN);

  logic [STEP_W-1:0] period_dec;

  // Compare in 32 bits so that STEP_MIN + STEP_DEC cannot wrap the counter width.
  assign period_dec = (32'(period) >= 32'(STEP_MIN + STEP_DEC)) ? period - PERIOD_DEC
                                                                 : PERIOD_MIN;

  // Updated at the hit; FREEZE never consults the period, so the new value
  // first matters on the RUN entry that follows the freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period <= PERIOD_INIT;
    end else if (state == RUN && press && pos == TGT_POS) begin
      period <= period_dec;
    end
  end
`else
  assign period = STEP_W'(STEP_CYCLES);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      btn_q    <= 1'b0;
      pos      <= '0;
      step_cnt <= '0;
      frz_cnt  <= '0;
      led      <= '0;
      score    <= 8'd0;
      hit      <= 1'b0;
      miss     <= 1'b0;
      frozen   <= 1'b0;
    end else begin
      btn_q <= btn;
      hit   <= 1'b0;
      miss  <= 1'b0;

      case (state)
        IDLE: begin
          led <= '0;
          if (press) begin
            state    <= RUN;
            pos      <= '0;
            step_cnt <= '0;
            led      <= LED_POS0;
          end
        end

        RUN: begin
          // A press on the terminal-count cycle is judged on the current
          // position, and the advance is dropped.
          if (press) begin
            if (pos == TGT_POS) begin
              hit <= 1'b1;
              if (score != 8'hFF) begin
                score <= score + 8'd1;
              end
            end else begin
              miss <= 1'b1;
            end
            state   <= FREEZE;
            frz_cnt <= '0;
            frozen  <= 1'b1;
          end else if (step_tc) begin
            step_cnt <= '0;
            pos      <= pos_next;
            led      <= LED_POS0 << pos_next;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end

        FREEZE: begin
          // led keeps the judged position; presses are not examined here.
          if (frz_cnt == FRZ_LAST) begin
            state    <= RUN;
            frozen   <= 1'b0;
            pos      <= '0;
            step_cnt <= '0;
            led      <= LED_POS0;
          end else begin
            frz_cnt <= frz_cnt + 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          led    <= '0;
          frozen <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_catcher_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_catcher_ctrl
// Purpose  : Self-checking bench for led_catcher_ctrl. A behavioural model
//            produces the expected outputs for every cycle; they are queued
//            when the stimulus is driven and compared on the following falling
//            edge. A table of press records plus hand-written sequences cover
//            hits, misses, held buttons, terminal-count presses, wrap-around,
//            mid-freeze reset, score saturation and step-period intervals.
// Options  : LED_CATCHER_SPEEDUP_EN - selects the speed-up expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_catcher_ctrl;

  localparam int NL = 8;
  localparam int TI = 3;
  localparam int SC = 4;
  localparam int FC = 10;
  localparam int SD = 1;
  localparam int SM = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn   = 1'b0;
  logic [NL-1:0] led;
  logic [7:0]    score;
  logic          hit;
  logic          miss;
  logic          frozen;

  always #5 clk = ~clk;

  led_catcher_ctrl #(
    .NUM_LEDS      (NL),
    .TARGET_IDX    (TI),
    .STEP_CYCLES   (SC),
    .FREEZE_CYCLES (FC),
    .STEP_DEC      (SD),
    .STEP_MIN      (SM)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (btn),
    .led    (led),
    .score  (score),
    .hit    (hit),
    .miss   (miss),
    .frozen (frozen)
  );

  typedef struct packed {
    logic [7:0] led;
    logic [7:0] score;
    logic       hit;
    logic       miss;
    logic       frozen;
  } obs_t;

  typedef struct {
    int pos;
    bit tc;
    bit hold;
    bit exp_hit;
    int exp_score;
  } vec_t;

  obs_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   ncyc     = 0;

  // ---------------- reference model ----------------
  typedef enum logic [1:0] {M_IDLE, M_RUN, M_FRZ} mst_t;
  mst_t m_st;
  int   m_pos, m_cnt, m_frz, m_per, m_score;
  logic m_btnq, m_hit, m_miss;

  task automatic model_reset();
    m_st = M_IDLE; m_pos = 0; m_cnt = 0; m_frz = 0; m_per = SC;
    m_score = 0; m_btnq = 1'b0; m_hit = 1'b0; m_miss = 1'b0;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.led    = (m_st == M_IDLE) ? 8'h00 : 8'(1 << m_pos);
    o.score  = 8'(m_score);
    o.hit    = m_hit;
    o.miss   = m_miss;
    o.frozen = (m_st == M_FRZ);
    return o;
  endfunction

  task automatic model_clock(input logic b);
    logic pr;
    pr     = b && !m_btnq;
    m_btnq = b;
    m_hit  = 1'b0;
    m_miss = 1'b0;
    case (m_st)
      M_IDLE: if (pr) begin m_st = M_RUN; m_pos = 0; m_cnt = 0; end
      M_RUN: begin
        if (pr) begin
          if (m_pos == TI) begin
            m_hit = 1'b1;
            if (m_score < 255) m_score++;
`ifdef LED_CATCHER_SPEEDUP_EN
            m_per = (m_per - SD > SM) ? m_per - SD : SM;
`endif
          end else begin
            m_miss = 1'b1;
          end
          m_st = M_FRZ; m_frz = 0;
        end else if (m_cnt == m_per - 1) begin
          m_cnt = 0; m_pos = (m_pos + 1) % NL;
        end else begin
          m_cnt++;
        end
      end
      default: begin
        m_frz++;
        if (m_frz == FC) begin m_st = M_RUN; m_pos = 0; m_cnt = 0; end
      end
    endcase
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_led"}, 32'(led), 0);
    chk({name, "_score"}, 32'(score), 0);
    chk({name, "_hit"}, 32'(hit), 0);
    chk({name, "_miss"}, 32'(miss), 0);
    chk({name, "_frozen"}, 32'(frozen), 0);
  endtask

  task automatic drive(input logic b);
    btn = b;
    model_clock(b);
    sb_q.push_back(model_obs());
  endtask

  task automatic check_cycle();
    @(negedge clk);
    ncyc++;
    if (sb_q.size() > 0) begin
      obs_t e, a;
      e = sb_q.pop_front();
      a = '{led: led, score: score, hit: hit, miss: miss, frozen: frozen};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle_%0d: got led=%h score=%0d hit=%b miss=%b frozen=%b, expected led=%h score=%0d hit=%b miss=%b frozen=%b",
                 ncyc, a.led, a.score, a.hit, a.miss, a.frozen,
                 e.led, e.score, e.hit, e.miss, e.frozen);
      end
    end
  endtask

  task automatic cycle(input logic b);
    check_cycle();
    drive(b);
  endtask

  // Run with btn low until the model says the next press would be judged at
  // position p (and, if tc, on the terminal-count cycle).
  task automatic wait_pos(input int p, input bit tc);
    int n = 0;
    cycle(1'b0);
    while (!(m_st == M_RUN && m_pos == p && (!tc || m_cnt == m_per - 1)) && n < 200) begin
      cycle(1'b0);
      n++;
    end
    chk("wait_pos_in_budget", 32'(n < 200), 1);
  endtask

  // Leave the caller on the first RUN cycle after the freeze.
  task automatic wait_unfreeze(input logic b);
    int n = 0;
    while (frozen && n < 40) begin
      cycle(b);
      n++;
    end
    chk("unfreeze_in_budget", 32'(n < 40), 1);
  endtask

  task automatic run_vec(input vec_t r, input int idx);
    int n;
    wait_pos(r.pos, r.tc);
    cycle(1'b1);
    cycle(r.hold);
    chk($sformatf("vec%0d_hit", idx), 32'(hit), 32'(r.exp_hit));
    chk($sformatf("vec%0d_miss", idx), 32'(miss), 32'(!r.exp_hit));
    chk($sformatf("vec%0d_score", idx), 32'(score), 32'(r.exp_score));
    chk($sformatf("vec%0d_frozen", idx), 32'(frozen), 1);
    chk($sformatf("vec%0d_led_held", idx), 32'(led), 32'(1 << r.pos));
    n = 1;
    for (int k = 0; k < 40; k++) begin
      cycle(r.hold);
      if (!frozen) break;
      n++;
    end
    chk($sformatf("vec%0d_freeze_len", idx), 32'(n), FC);
    chk($sformatf("vec%0d_led_restart", idx), 32'(led), 32'h01);
    if (r.hold) begin
      for (int k = 0; k < 5; k++) begin
        cycle(1'b1);
        chk($sformatf("vec%0d_hold_no_pulse", idx), 32'({hit, miss}), 0);
      end
    end
  endtask

  // Called on the first RUN cycle (led just became position 0).
  task automatic measure(input int exp_per, input string name);
    int n = 0;
    while (led == 8'h01 && n < 50) begin
      cycle(1'b0);
      n++;
    end
    chk(name, 32'(n), 32'(exp_per));
    chk({name, "_led"}, 32'(led), 32'h02);
  endtask

  task automatic do_hit();
    wait_pos(TI, 1'b0);
    cycle(1'b1);
    cycle(1'b0);
    wait_unfreeze(1'b0);
  endtask

  // ---------------- main sequence ----------------
  vec_t vt [8];
  int   exp_int [4];

  initial begin
    vt[0] = '{pos: 3, tc: 0, hold: 0, exp_hit: 1, exp_score: 1};
    vt[1] = '{pos: 5, tc: 0, hold: 1, exp_hit: 0, exp_score: 1};
    vt[2] = '{pos: 3, tc: 1, hold: 0, exp_hit: 1, exp_score: 2};
    vt[3] = '{pos: 0, tc: 0, hold: 0, exp_hit: 0, exp_score: 2};
    vt[4] = '{pos: 7, tc: 0, hold: 0, exp_hit: 0, exp_score: 2};
    vt[5] = '{pos: 3, tc: 0, hold: 1, exp_hit: 1, exp_score: 3};
    vt[6] = '{pos: 3, tc: 1, hold: 0, exp_hit: 1, exp_score: 4};
    vt[7] = '{pos: 6, tc: 0, hold: 0, exp_hit: 0, exp_score: 4};
`ifdef LED_CATCHER_SPEEDUP_EN
    exp_int = '{4, 3, 2, 2};
`else
    exp_int = '{4, 4, 4, 4};
`endif

    model_reset();
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0);

    // Idle with the button released.
    repeat (20) cycle(1'b0);
    chk_zero("idle");

    // Start the game, first step after STEP_CYCLES.
    cycle(1'b1);
    cycle(1'b0);
    chk("run_entry_led", 32'(led), 32'h01);
    chk("run_entry_pulses", 32'({hit, miss, frozen}), 0);
    repeat (3) cycle(1'b0);
    chk("pre_step_led", 32'(led), 32'h01);
    cycle(1'b0);
    chk("first_step_led", 32'(led), 32'h02);

    // Wrap from the last LED back to the first.
    wait_pos(NL - 1, 1'b0);
    cycle(1'b0);
    chk("wrap_last_led", 32'(led), 32'h80);
    for (int k = 0; k < 10; k++) begin
      if (led != 8'h80) break;
      cycle(1'b0);
    end
    chk("wrap_first_led", 32'(led), 32'h01);

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // Reach score 5 and reset in the middle of the freeze.
    wait_pos(TI, 1'b0);
    cycle(1'b1);
    cycle(1'b0);
    chk("pre_reset_score", 32'(score), 5);
    chk("pre_reset_frozen", 32'(frozen), 1);
    repeat (3) cycle(1'b0);
    #2;
    rst_n = 1'b0;
    btn   = 1'b1;
    #1;
    chk_zero("mid_freeze_reset");
    sb_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1);

    // Button already high at reset release counts as a press.
    cycle(1'b1);
    chk("release_press_led", 32'(led), 32'h01);
    chk("release_press_state", 32'({score, hit, miss, frozen}), 0);

    // Step intervals across successive hits.
    measure(exp_int[0], "interval0");
    do_hit();
    measure(exp_int[1], "interval1");
    do_hit();
    measure(exp_int[2], "interval2");
    do_hit();
    measure(exp_int[3], "interval3");
    chk("interval_score", 32'(score), 3);

    // Saturation.
    for (int i = 0; i < 256; i++) do_hit();
    chk("score_saturated", 32'(score), 255);
    cycle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
